// File: rtl/io_stimulus_gen.sv
// io_stimulus_gen: upstream stimulus source for designA.
// Plays a preloaded table of signed values, one entry per big-clock step. Each step
// raises a one-cycle posedge_big_clk pulse. On that same cycle input_signal and
// step_index change to the new entry.
//
// Ports:
//   clk             system clock, rising edge
//   reset_n         asynchronous active-low reset
//   enable          run request (level)
//   loop            1: wrap to entry 0 after the last entry, 0: stop in DONE
//   seq_len         number of valid entries; 0 acts as 1, values above DEPTH act as DEPTH
//   load_we         RAM write strobe; load_data is clamped to [-999, 999] before it is stored
//   load_addr       RAM write index
//   load_data       RAM write value (signed)
//   posedge_big_clk one-clk-wide step pulse
//   input_signal    current stimulus value
//   step_index      index of the value on input_signal
//   done            sequence finished (non-loop mode)
module io_stimulus_gen #(
    parameter int unsigned BIG_CLK_PERIOD = 22,
    parameter int unsigned DEPTH          = 64,
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned DATA_W         = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              loop,
    input  logic [ADDR_W:0]   seq_len,
    input  logic              load_we,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              posedge_big_clk,
    output logic [DATA_W-1:0] input_signal,
    output logic [ADDR_W-1:0] step_index,
    output logic              done
);

    localparam int unsigned CntW = $clog2(BIG_CLK_PERIOD);
    localparam logic [CntW-1:0] CntLast = CntW'(BIG_CLK_PERIOD - 1);
    localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(DEPTH);
    localparam logic signed [DATA_W-1:0] ValMax = DATA_W'(999);
    localparam logic signed [DATA_W-1:0] ValMin = DATA_W'(-999);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                pulse_q, pulse_d;
    logic [DATA_W-1:0]   sig_q, sig_d;
    logic [ADDR_W-1:0]   sidx_q, sidx_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   rd_data;
    logic signed [DATA_W-1:0] load_val;
    logic signed [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]     len_eff;
    logic                last_entry;

    // Clamp the incoming value into the legal range before it is stored.
    always_comb begin
        load_val = $signed(load_data);
        if (load_val > ValMax) begin
            wr_data = ValMax;
        end else if (load_val < ValMin) begin
            wr_data = ValMin;
        end else begin
            wr_data = load_val;
        end
    end

    // Stimulus RAM: written in any state, contents survive reset.
    always_ff @(posedge clk) begin
        if (load_we && (32'(load_addr) < DEPTH)) begin
            mem[load_addr] <= wr_data;
        end
    end

    // Read happens before a same-edge write lands, so a colliding write shows up
    // only on the next visit to that entry.
    assign rd_data = mem[idx_q];

    always_comb begin
        if (seq_len == '0) begin
            len_eff = (ADDR_W + 1)'(1);
        end else if (seq_len > DepthLen) begin
            len_eff = DepthLen;
        end else begin
            len_eff = seq_len;
        end
    end

    assign last_entry = ({1'b0, idx_q} == (len_q - (ADDR_W + 1)'(1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        pulse_d = 1'b0;
        sig_d   = sig_q;
        sidx_d  = sidx_q;
        done_d  = done_q;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (enable) begin
                    state_d = StRun;
                    len_d   = len_eff;
                end
            end

            StRun: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    sig_d   = rd_data;
                    sidx_d  = idx_q;
                    if (last_entry) begin
                        if (loop) begin
                            idx_d = '0;
                        end else begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end

                // Pausing keeps idx so a later run resumes; a pulse due on this
                // edge has already been scheduled above and still fires.
                if (!enable) begin
                    cnt_d = '0;
                    if (state_d == StDone) begin
                        idx_d  = '0;
                        done_d = 1'b0;
                    end
                    state_d = StIdle;
                end
            end

            StDone: begin
                if (!enable) begin
                    state_d = StIdle;
                    done_d  = 1'b0;
                    idx_d   = '0;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= (ADDR_W + 1)'(1);
            pulse_q <= 1'b0;
            sig_q   <= '0;
            sidx_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            pulse_q <= pulse_d;
            sig_q   <= sig_d;
            sidx_q  <= sidx_d;
            done_q  <= done_d;
        end
    end

    assign posedge_big_clk = pulse_q;
    assign input_signal    = sig_q;
    assign step_index      = sidx_q;
    assign done            = done_q;

endmodule

// File: tb/tb_io_stimulus_gen.sv
module tb_io_stimulus_gen;

    localparam int P     = 22;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 11;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic          loop = 1'b0;
    logic [AW:0]   seq_len = '0;
    logic          load_we = 1'b0;
    logic [AW-1:0] load_addr = '0;
    logic [DW-1:0] load_data = '0;
    logic          posedge_big_clk;
    logic [DW-1:0] input_signal;
    logic [AW-1:0] step_index;
    logic          done;

    int            total_cnt = 0;
    int            pass_cnt = 0;
    int            ref_mem[DEPTH];
    logic [DW-1:0] exp_sig = '0;
    int            exp_idx = 0;

    io_stimulus_gen #(
        .BIG_CLK_PERIOD(P),
        .DEPTH(DEPTH),
        .ADDR_W(AW),
        .DATA_W(DW)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .enable(enable),
        .loop(loop),
        .seq_len(seq_len),
        .load_we(load_we),
        .load_addr(load_addr),
        .load_data(load_data),
        .posedge_big_clk(posedge_big_clk),
        .input_signal(input_signal),
        .step_index(step_index),
        .done(done)
    );

    always #5 clk = ~clk;

    function automatic int clamp_val(logic [DW-1:0] raw);
        int v;
        v = int'($signed(raw));
        if (v > 999) v = 999;
        if (v < -999) v = -999;
        return v;
    endfunction

    function automatic int eff_len(int s);
        if (s == 0) return 1;
        if (s > DEPTH) return DEPTH;
        return s;
    endfunction

    task automatic write_entry(int addr, logic [DW-1:0] raw);
        @(negedge clk);
        load_we   = 1'b1;
        load_addr = addr[AW-1:0];
        load_data = raw;
        @(negedge clk);
        load_we   = 1'b0;
        ref_mem[addr] = clamp_val(raw);
    endtask

    task automatic do_reset();
        enable  = 1'b0;
        load_we = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        exp_sig = '0;
        exp_idx = 0;
    endtask

    // k counts cycles since the edge that moved the DUT into RUN (k=0 is that edge).
    // Step n (n>=1) lands at k = n*P and presents entry start_entry+n-1.
    task automatic run_window(string name, int k_first, int n_obs, int len, bit lp,
                              int start_entry);
        for (int k = k_first; k < k_first + n_obs; k++) begin
            bit exp_pulse;
            bit exp_done;
            int n;
            int e;
            @(negedge clk);
            n = k / P;
            exp_pulse = (k > 0) && (k % P == 0) && (lp || (n <= len - start_entry));
            if (exp_pulse) begin
                e = (start_entry + n - 1) % len;
                exp_sig = DW'(ref_mem[e]);
                exp_idx = e;
            end
            exp_done = !lp && (k >= (len - start_entry) * P);

            total_cnt++;
            if (posedge_big_clk !== exp_pulse)
                $display("FAIL %s pulse k=%0d got %0b want %0b", name, k, posedge_big_clk,
                         exp_pulse);
            else pass_cnt++;

            total_cnt++;
            if (input_signal !== exp_sig)
                $display("FAIL %s input_signal k=%0d got %0d want %0d", name, k,
                         $signed(input_signal), $signed(exp_sig));
            else pass_cnt++;

            total_cnt++;
            if (step_index !== AW'(exp_idx))
                $display("FAIL %s step_index k=%0d got %0d want %0d", name, k, step_index,
                         exp_idx);
            else pass_cnt++;

            total_cnt++;
            if (done !== exp_done)
                $display("FAIL %s done k=%0d got %0b want %0b", name, k, done, exp_done);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_cnt++;
        if ({posedge_big_clk, input_signal, step_index, done} !== '0)
            $display("FAIL reset outputs got p=%0b sig=%0d idx=%0d done=%0b want all 0",
                     posedge_big_clk, input_signal, step_index, done);
        else pass_cnt++;
        reset_n = 1'b1;
    endtask

    task automatic test_pulse_timing();
        do_reset();
        write_entry(0, DW'(5));
        write_entry(1, DW'(-7));
        write_entry(2, DW'(999));
        seq_len = 7'd3;
        loop    = 1'b1;
        enable  = 1'b1;
        run_window("timing", 0, 90, 3, 1'b1, 0);
    endtask

    task automatic test_clamp();
        do_reset();
        write_entry(0, DW'(1023));
        write_entry(1, 11'h400);
        for (int i = 2; i < 8; i++) write_entry(i, DW'($urandom));
        seq_len = 7'd8;
        loop    = 1'b1;
        enable  = 1'b1;
        run_window("clamp", 0, 9 * P + 1, 8, 1'b1, 0);
    endtask

    task automatic test_nonloop();
        do_reset();
        write_entry(0, DW'($urandom_range(1, 999)));
        write_entry(1, DW'(-int'($urandom_range(1, 999))));
        seq_len = 7'd2;
        loop    = 1'b0;
        enable  = 1'b1;
        run_window("nonloop", 0, 80, 2, 1'b0, 0);
        enable = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b0) $display("FAIL nonloop_clear done got %0b want 0", done);
        else pass_cnt++;
        total_cnt++;
        if (input_signal !== exp_sig)
            $display("FAIL nonloop_hold input_signal got %0d want %0d",
                     $signed(input_signal), $signed(exp_sig));
        else pass_cnt++;
        // Leaving DONE rewinds to entry 0.
        enable = 1'b1;
        run_window("nonloop_rerun", 0, 2 * P + 1, 2, 1'b0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 5; r++) begin
            int sl;
            int nfill;
            bit lp;
            do_reset();
            if (r == 4) begin
                sl = 100;
                lp = 1'b0;
            end else begin
                sl = $urandom_range(0, 8);
                lp = 1'($urandom_range(0, 1));
            end
            nfill = eff_len(sl);
            for (int i = 0; i < nfill; i++) write_entry(i, DW'($urandom));
            seq_len = 7'(sl);
            loop    = lp;
            enable  = 1'b1;
            run_window("random", 0, (eff_len(sl) + 2) * P, eff_len(sl), lp, 0);
        end
    endtask

    task automatic test_pause_resume();
        do_reset();
        for (int i = 0; i < 3; i++) write_entry(i, DW'($urandom_range(1, 999)));
        seq_len = 7'd3;
        loop    = 1'b1;
        enable  = 1'b1;
        run_window("pause_a", 0, 31, 3, 1'b1, 0);
        enable = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            total_cnt++;
            if (posedge_big_clk !== 1'b0 || input_signal !== exp_sig)
                $display("FAIL pause_idle c=%0d got p=%0b sig=%0d want p=0 sig=%0d", c,
                         posedge_big_clk, $signed(input_signal), $signed(exp_sig));
            else pass_cnt++;
        end
        enable = 1'b1;
        run_window("pause_b", 0, P + 1, 3, 1'b1, 1);
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 4; i++) write_entry(i, DW'($urandom_range(1, 999)));
        seq_len = 7'd4;
        loop    = 1'b1;
        enable  = 1'b1;
        run_window("areset_a", 0, 41, 4, 1'b1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({posedge_big_clk, input_signal, step_index, done} !== '0)
            $display("FAIL areset_now got p=%0b sig=%0d idx=%0d done=%0b want all 0",
                     posedge_big_clk, input_signal, step_index, done);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        exp_sig = '0;
        exp_idx = 0;
        run_window("areset_b", 0, P + 1, 4, 1'b1, 0);
    endtask

    task automatic test_write_during_read();
        logic [DW-1:0] c_raw;
        do_reset();
        write_entry(0, DW'($urandom));
        write_entry(1, DW'($urandom));
        do c_raw = DW'($urandom); while (clamp_val(c_raw) == ref_mem[0]);
        seq_len = 7'd2;
        loop    = 1'b1;
        enable  = 1'b1;
        run_window("wdr_a", 0, 22, 2, 1'b1, 0);
        load_we   = 1'b1;
        load_addr = '0;
        load_data = c_raw;
        run_window("wdr_edge", 22, 1, 2, 1'b1, 0);
        load_we = 1'b0;
        ref_mem[0] = clamp_val(c_raw);
        run_window("wdr_wrap", 23, 44, 2, 1'b1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_pulse_timing();
        test_clamp();
        test_nonloop();
        test_random();
        test_pause_resume();
        test_async_reset();
        test_write_during_read();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/io_stimulus_gen.md
Name: io_stimulus_gen

Overview:
- Upstream stimulus stage for designA. It generates the big-clock step pulse (posedge_big_clk) and the 11-bit input_signal that the design consumes.
- Plays a preloaded sequence of signed Shenzhen-range values from an internal RAM, advancing one entry per big-clock step.
- Replaces the ad-hoc counter and pulse logic in benches with a reusable, resettable source.

Parameters:
- BIG_CLK_PERIOD, 22, clk cycles per big-clock step (minimum 2)
- DEPTH, 64, number of stimulus entries
- ADDR_W, 6, index width; DEPTH must be at most 2^ADDR_W
- DATA_W, 11, signal width, signed two's complement

Ports:
- clk  in  1  system clock, rising-edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run request, level-sensitive
- loop  in  1  1 = wrap to entry 0 after last entry; 0 = stop
- seq_len  in  ADDR_W+1  number of valid entries (1..DEPTH)
- load_we  in  1  RAM write strobe
- load_addr  in  ADDR_W  RAM write index
- load_data  in  DATA_W  RAM write value (signed)
- posedge_big_clk  out  1  one-clk-wide step pulse
- input_signal  out  DATA_W  current stimulus value to designA
- step_index  out  ADDR_W  index of the value currently on input_signal
- done  out  1  sequence finished (non-loop mode)

Behaviour:
- Reset (async assert, sync release) drives outputs and state as follows:
  - posedge_big_clk=0, input_signal=0, step_index=0, done=0
  - divider cnt=0, state=IDLE
  - RAM contents are not reset.
- RAM writes:
  - On a clk edge with load_we=1, store load_data clamped to [-999, 999] at load_addr.
  - Clamp examples: 1023 becomes 999; -1024 becomes -999.
  - Writes are accepted in every state.
- States: IDLE, RUN, DONE.
- IDLE:
  - Outputs hold their values; cnt=0.
  - enable=1 moves to RUN on the next edge; cnt starts at 0.
- RUN:
  - cnt increments each clk.
  - On the edge where cnt==BIG_CLK_PERIOD-1, all of the following happen on that same edge:
    - cnt goes to 0;
    - posedge_big_clk is registered 1 for exactly one cycle;
    - input_signal is loaded with RAM[idx];
    - step_index is loaded with idx.
  - The value and the pulse therefore change together, and the value is stable for the whole step.
- First step: the first pulse occurs BIG_CLK_PERIOD cycles after entering RUN and presents entry 0.
- Index advance:
  - After a step presents entry seq_len-1, idx wraps to 0 if loop=1.
  - If loop=0, the state goes to DONE instead.
- DONE:
  - done=1; no further pulses.
  - input_signal holds the last value.
  - enable=0 returns to IDLE, clears done, and resets idx to 0.
- enable deasserted in RUN:
  - Return to IDLE on the next edge.
  - cnt clears; idx is retained, so a later RUN resumes from the next entry.
  - A pulse scheduled on that same edge still fires.
- seq_len handling:
  - seq_len is sampled only on the IDLE-to-RUN transition.
  - seq_len=0 is treated as 1.
  - seq_len>DEPTH is treated as DEPTH.
- Simultaneous write and read: a write to the entry being read on the step edge presents the old value; the new value appears on the next wrap.
- Reset asserted mid-step: immediate return to reset values; no partial pulse.

Test Plan:
- Reset and pulse timing: load [5, -7, 999], seq_len=3, loop=1, enable=1.
  - Pulses at cycles 22, 44, 66 and 88.
  - input_signal follows 5, -7, 999, 5.
  - Each pulse is exactly 1 cycle wide.
- Clamp: write 1023 to entry 0 and 0x400 (-1024) to entry 1, then run.
  - input_signal shows 999, then -999.
- Non-loop: seq_len=2, loop=0.
  - After 2 pulses, done=1 and no pulse at cycle 66.
  - input_signal holds entry 1.
  - enable=0 clears done.
- Pause and resume: drop enable at cycle 30 and reassert at cycle 50.
  - The next pulse comes 22 cycles after RUN re-entry.
  - It presents entry 1, not entry 0.
- Async reset mid-run: pull reset_n low at cycle 40 with no clk edge.
  - Outputs go to 0 immediately.
  - After release with enable=1, the first pulse presents entry 0.
- Integration with designA: connect to designA with both instruction memories loaded.
  - posedge_big_clk period is 22 clk cycles.
  - input_signal changes only on pulse cycles.
